seq_detector: RTL
=================

# seq_detector

Parametrised serial pattern detector: it watches a 1-bit input stream qualified by a valid strobe and flags each occurrence of a programmable N-bit pattern. It supports overlapping and non-overlapping match modes and can optionally keep a saturating count of matches. It is the general-purpose successor to the fixed two-bit detector and serves as a reusable stream/sync-word matcher in the multi-cycle CPU peripherals.

## Interface
- `N`, 4: pattern length in bits; legal range 2..32.
- `CNT_W`, 8: width of the match counter; legal range 1..32.

- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `en`  in  1  `a` is valid this cycle.
- `a`  in  1  serial data bit.
- `load`  in  1  latch `pattern` and flush the bit history.
- `pattern`  in  N  pattern value. The oldest bit is compared against `pattern[N-1]`; the newest bit against `pattern[0]`.
- `overlap`  in  1  1 = overlapping matches allowed; 0 = history restarts after each match. Sampled every accepted bit.
- `clr`  in  1  synchronous clear of `match_cnt`.
- `armed`  out  1  a pattern has been loaded (FSM is not in IDLE).
- `y`  out  1  one-cycle match pulse.
- `match_cnt`  out  CNT_W  saturating match count.

## Operation
- **Registers:**
  - `pat[N-1:0]`: latched pattern.
  - `hist[N-1:0]`: bit history.
  - `fill`: 0..N, the number of valid history bits.
  - FSM `state`.
  - `y`.
  - `match_cnt`.
- **FSM states:** IDLE, FILL, RUN.
  - IDLE: all `en` bits are ignored. `load` → FILL.
  - FILL: while `fill < N-1`, each accepted bit shifts into history (`hist <= {hist[N-2:0], a}`) and increments `fill`.
  - FILL → RUN: on the accepted bit that makes `fill` reach N.
  - RUN: each accepted bit shifts in; `fill` stays at N.
  - `load` in any state: `pat <= pattern`, `fill <= 0`, `hist <= 0`, next state FILL. The same-cycle `en` bit is discarded.
- **Match condition:** `en & (state != IDLE) & ~load & (fill >= N-1) & ({hist[N-2:0], a} == pat)`.
  - On a match: `y` is registered high for exactly one cycle.
  - If `overlap = 1`: `fill` becomes N and the state is RUN.
  - If `overlap = 0`: `fill <= 0`, `hist <= 0`, state FILL. The bits of the match are never reused.
- **Counter:**
  - On a match, `match_cnt` increments and saturates at 2^CNT_W − 1.
  - `clr` forces it to 0 and takes priority over a same-cycle match. The `y` pulse still occurs.
- **Input gaps:** when `en = 0`, history, `fill` and state hold.
- **Reset values:** state IDLE, `armed = 0`, `y = 0`, `match_cnt = 0`, `pat = 0`, `hist = 0`, `fill = 0`.
- **Reset mid-operation:** returns immediately to the reset values. A pattern must be re-loaded before any match is possible.

## Timing
- `y` rises on the clock edge that samples the final pattern bit and stays high for that one cycle. It is a registered Moore-style output with no combinational path from `a`.
- `match_cnt` updates on the same edge as `y` rises.
- `armed` is high starting from the edge that samples `load`.
- Back-to-back matches in overlap mode can produce `y` high on consecutive cycles. Example: N = 2, pattern `11`, input stream `1 1 1`.
- Minimum spacing between matches in non-overlap mode: N accepted bits.

## Configuration
- `SEQDET_CNT_EN`
  - Defined: the `match_cnt` counter and `clr` logic are built as described above.
  - Undefined: no counter register is built. `match_cnt` is tied to 0, `clr` is ignored, and `y`/FSM behaviour is unchanged.

## Structure
- Package `seqdet_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, FILL, RUN} seqdet_state_t`
  - localparams `SEQDET_N_MIN = 2` and `SEQDET_N_MAX = 32`, used for elaboration-time parameter checks.
- One sub-module: `seqdet_sat_cnt`, a parametrised saturating counter with synchronous clear. It is instantiated only under `SEQDET_CNT_EN`.

## Test plan
All scenarios use N = 4 and `pattern = 4'b1011`, loaded first.
- **Overlap:** `overlap = 1`, stream `1,0,1,1,0,1,1` with `en = 1` → `y` pulses after bit 4 and after bit 7; `match_cnt = 2`.
- **Non-overlap:** `overlap = 0`, same stream → `y` pulses only after bit 4; `match_cnt = 1`; state is FILL with `fill = 3` at the end.
- **Gaps and reload:** insert `en = 0` gaps between every bit → same results as without gaps. Assert `load` after bits `1,0,1` → no `y` on the following `1`; a fresh `1,0,1,1` gives one pulse.
- **Saturation:** with `CNT_W = 2`, produce 5 matches → `match_cnt = 3`. Then `clr` coincident with a 6th match → `y = 1`, `match_cnt = 0`.
- **Before load:** stream `1,0,1,1` with no `load` after reset → `y` stays 0 and `armed` stays 0.
- **Reset mid-run:** `reset` asserted mid-RUN → all outputs are 0 immediately; the stream `1,0,1,1` yields no match until after a new `load`. Build without `SEQDET_CNT_EN` → `match_cnt` is constantly 0.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared types and parameter limits for the serial pattern detector.
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } seqdet_state_t;

  localparam int unsigned SEQDET_N_MIN = 2;
  localparam int unsigned SEQDET_N_MAX = 32;

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seqdet_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count events, holding at all-ones once reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_detector.sv
// Serial N-bit pattern detector with overlap / non-overlap modes.
// Optional saturating match counter built when SEQDET_CNT_EN is defined.
module seq_detector
  import seqdet_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             load,
  input  logic [N-1:0]     pattern,
  input  logic             overlap,
  input  logic             clr,
  output logic             armed,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

  if ((N < SEQDET_N_MIN) || (N > SEQDET_N_MAX)) begin : g_bad_n
    $error("seq_detector: N out of legal range");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
    $error("seq_detector: CNT_W out of legal range");
  end

  seqdet_state_t     r_state, w_state_nxt;
  logic [N-1:0]      r_pat, w_pat_nxt;
  logic [N-1:0]      r_hist, w_hist_nxt;
  logic [FILL_W-1:0] r_fill, w_fill_nxt;
  logic              r_y;
  logic              r_armed;
  logic [N-1:0]      w_shift;
  logic              w_match;

  // State, pattern, history and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_y     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_y     <= w_match;
      r_armed <= (w_state_nxt != IDLE);
    end
  end

  // Next-state, history update and match detection.
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_shift     = {r_hist[N-2:0], a};
    w_match     = 1'b0;

    if (load) begin
      // A load flushes history; the same-cycle data bit is dropped.
      w_pat_nxt   = pattern;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = FILL;
    end else if (en && (r_state != IDLE)) begin
      if ((r_fill >= FILL_LAST) && (w_shift == r_pat)) begin
        w_match = 1'b1;
        if (overlap) begin
          w_hist_nxt  = w_shift;
          w_fill_nxt  = FILL_FULL;
          w_state_nxt = RUN;
        end else begin
          // Matched bits are consumed; start over from empty history.
          w_hist_nxt  = '0;
          w_fill_nxt  = '0;
          w_state_nxt = FILL;
        end
      end else begin
        w_hist_nxt = w_shift;
        if (r_fill < FILL_FULL) begin
          w_fill_nxt = r_fill + FILL_W'(1);
        end
        if (r_fill >= FILL_LAST) begin
          w_state_nxt = RUN;
        end
      end
    end
  end

  assign y     = r_y;
  assign armed = r_armed;

`ifdef SEQDET_CNT_EN
  seqdet_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .inc  (w_match),
    .cnt  (match_cnt)
  );
`else
  logic w_unused_clr;
  assign w_unused_clr = clr;
  assign match_cnt    = '0;
`endif

endmodule
